// File: rtl/wb_reg_file.sv
// Write-back stage and integer register file for the 5-stage RV64 pipeline.
// Selects the write-back value, commits it to the register array and serves two bypassed read ports.
module wb_reg_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNTW  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] wb_read_data,
  input  logic [XLEN-1:0] wb_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_mem_to_reg,
  input  logic            wb_reg_write,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      last_rd,
  output logic            last_valid,
  output logic [CNTW-1:0] retire_count
);

  logic [XLEN-1:0] regs [NREGS];
  logic            commit;

  assign wb_data = wb_mem_to_reg ? wb_read_data : wb_result;

  // wb_reg_write is evaluated first so an undriven wb_rd cannot produce a commit.
  assign commit = wb_reg_write && (wb_rd != 5'd0) && !reset;

  // Write-first bypass: a read of the register being committed sees the new value.
  assign rs1_data = (rs1 == 5'd0)                ? '0      :
                    (commit && (wb_rd == rs1))   ? wb_data : regs[rs1];
  assign rs2_data = (rs2 == 5'd0)                ? '0      :
                    (commit && (wb_rd == rs2))   ? wb_data : regs[rs2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the array is cleared by reset because reads during and after reset must return zero;
      // this rules out mapping it onto a RAM macro without a clear port.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      last_rd      <= '0;
      last_valid   <= 1'b0;
      retire_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      last_valid <= commit;
      if (commit) begin
        regs[wb_rd]  <= wb_data;
        last_rd      <= wb_rd;
        retire_count <= retire_count + CNTW'(1);
      end
    end
  end

endmodule
